// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_pkg                                                     |
// | Description : Shared opcodes, state/class enums and per-state outputs.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

  localparam logic [6:0] c_OPC_R    = 7'b0110011;
  localparam logic [6:0] c_OPC_I    = 7'b0010011;
  localparam logic [6:0] c_OPC_LW   = 7'b0000011;
  localparam logic [6:0] c_OPC_SW   = 7'b0100011;
  localparam logic [6:0] c_OPC_BR   = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL  = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR = 7'b1100111;

  localparam logic [1:0] c_ALU_MEM = 2'b00;
  localparam logic [1:0] c_ALU_BR  = 2'b01;
  localparam logic [1:0] c_ALU_RI  = 2'b10;
  localparam logic [1:0] c_ALU_JMP = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_WB_ALU = 4'd5,
    ST_WB_MEM = 4'd6,
    ST_BRANCH = 4'd7,
    ST_JUMP   = 4'd8,
    ST_TRAP   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BR      = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_JALR    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } iclass_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       done;
  } ctrl_out_t;

  // Moore outputs for a state; the handshake-qualified strobes are added by the top.
  function automatic ctrl_out_t state_outputs(state_t st, iclass_t cls);
    ctrl_out_t o;
    logic      is_mem;
    o      = '0;
    is_mem = (cls == CLS_LW) || (cls == CLS_SW);
    case (st)
      ST_FETCH:  o.mem_req = 1'b1;
      ST_EXEC: begin
        o.alu_src = (cls != CLS_R);
        o.alu_op  = is_mem ? c_ALU_MEM : c_ALU_RI;
      end
      ST_MEM_RD: begin
        o.mem_req = 1'b1;
        o.iord    = 1'b1;
      end
      ST_MEM_WR: begin
        o.mem_req = 1'b1;
        o.iord    = 1'b1;
        o.mem_we  = 1'b1;
        o.alu_src = 1'b1;
      end
      ST_WB_ALU: begin
        o.reg_write = 1'b1;
        o.alu_src   = (cls != CLS_R);
        o.alu_op    = c_ALU_RI;
        o.done      = 1'b1;
      end
      ST_WB_MEM: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
        o.done       = 1'b1;
      end
      ST_BRANCH: begin
        o.branch = 1'b1;
        o.alu_op = c_ALU_BR;
        o.done   = 1'b1;
      end
      ST_JUMP: begin
        o.jump      = 1'b1;
        o.reg_write = 1'b1;
        o.alu_op    = c_ALU_JMP;
        o.done      = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller_if                                     |
// | Description : Controller <-> datapath/memory strobe bundle.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       mem_to_reg;
  logic       reg_write;
  logic       branch;
  logic       jump;
  logic       instr_done;
  logic       illegal;
  logic       timeout;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, alu_src, alu_op,
           mem_to_reg, reg_write, branch, jump, instr_done, illegal, timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, alu_src, alu_op,
           mem_to_reg, reg_write, branch, jump, instr_done, illegal, timeout
  );
endinterface
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : opcode_decoder                                               |
// | Description : Combinational opcode to instruction-class map.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module opcode_decoder
  import ctrl_pkg::*;
(
  input  wire logic [6:0] i_opcode,
  output iclass_t         o_class
);

  always_comb begin
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      c_OPC_R:    o_class = CLS_R;
      c_OPC_I:    o_class = CLS_I;
      c_OPC_LW:   o_class = CLS_LW;
      c_OPC_SW:   o_class = CLS_SW;
      c_OPC_BR:   o_class = CLS_BR;
      c_OPC_JAL:  o_class = CLS_JAL;
      c_OPC_JALR: o_class = CLS_JALR;
      default:    o_class = CLS_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller                                        |
// | Description : Multicycle CPU control FSM with memory-request timeout.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic                clk,
  input  wire logic                reset,
  multicycle_controller_if.master  bus
);

  localparam int                 c_CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam bit                 c_TO_EN    = (MEM_TIMEOUT > 0);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t               r_state;
  iclass_t              r_class;
  ctrl_out_t            r_out;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_illegal;
  logic                 r_timeout;

  iclass_t              w_class;
  logic                 w_expire;
  logic                 w_fetch_ack;
  logic                 w_store_ack;

  opcode_decoder u_dec (
    .i_opcode (bus.opcode),
    .o_class  (w_class)
  );

  // Only meaningful in a request cycle: this unanswered cycle is the last one allowed.
  assign w_expire    = c_TO_EN && (r_cnt == c_CNT_LAST);
  // The first FETCH cycle after reset has mem_req low, so mem_ready is ignored there.
  assign w_fetch_ack = (r_state == ST_FETCH) && r_out.mem_req && bus.mem_ready;
  assign w_store_ack = (r_state == ST_MEM_WR) && bus.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_class   <= CLS_ILLEGAL;
      r_out     <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (!r_out.mem_req) begin
            r_out <= state_outputs(ST_FETCH, r_class);
          end else if (bus.mem_ready) begin
            r_state <= ST_DECODE;
            r_out   <= state_outputs(ST_DECODE, r_class);
            r_cnt   <= '0;
          end else if (w_expire) begin
            r_state   <= ST_TRAP;
            r_out     <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          r_class <= w_class;
          case (w_class)
            CLS_R, CLS_I, CLS_LW, CLS_SW: begin
              r_state <= ST_EXEC;
              r_out   <= state_outputs(ST_EXEC, w_class);
            end
            CLS_BR: begin
              r_state <= ST_BRANCH;
              r_out   <= state_outputs(ST_BRANCH, w_class);
            end
            CLS_JAL, CLS_JALR: begin
              r_state <= ST_JUMP;
              r_out   <= state_outputs(ST_JUMP, w_class);
            end
            default: begin
              r_state   <= ST_TRAP;
              r_out     <= '0;
              r_illegal <= 1'b1;
            end
          endcase
        end
        ST_EXEC: begin
          r_cnt <= '0;
          case (r_class)
            CLS_LW: begin
              r_state <= ST_MEM_RD;
              r_out   <= state_outputs(ST_MEM_RD, r_class);
            end
            CLS_SW: begin
              r_state <= ST_MEM_WR;
              r_out   <= state_outputs(ST_MEM_WR, r_class);
            end
            default: begin
              r_state <= ST_WB_ALU;
              r_out   <= state_outputs(ST_WB_ALU, r_class);
            end
          endcase
        end
        ST_MEM_RD, ST_MEM_WR: begin
          if (bus.mem_ready) begin
            r_state <= (r_state == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
            r_out   <= state_outputs((r_state == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH, r_class);
            r_cnt   <= '0;
          end else if (w_expire) begin
            r_state   <= ST_TRAP;
            r_out     <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
          r_state <= ST_FETCH;
          r_out   <= state_outputs(ST_FETCH, r_class);
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_TRAP;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign bus.mem_req    = r_out.mem_req;
  assign bus.mem_we     = r_out.mem_we;
  assign bus.iord       = r_out.iord;
  assign bus.ir_write   = w_fetch_ack;
  assign bus.pc_write   = w_fetch_ack;
  assign bus.alu_src    = r_out.alu_src;
  assign bus.alu_op     = r_out.alu_op;
  assign bus.mem_to_reg = r_out.mem_to_reg;
  assign bus.reg_write  = r_out.reg_write;
  assign bus.branch     = r_out.branch;
  assign bus.jump       = r_out.jump;
  assign bus.instr_done = r_out.done | w_store_ack;
  assign bus.illegal    = r_illegal;
  assign bus.timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_controller                                     |
// | Description : Directed + random bench against a per-instruction model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

  localparam int c_TO = 4;

  localparam logic [6:0] c_R    = 7'b0110011;
  localparam logic [6:0] c_I    = 7'b0010011;
  localparam logic [6:0] c_LW   = 7'b0000011;
  localparam logic [6:0] c_SW   = 7'b0100011;
  localparam logic [6:0] c_BR   = 7'b1100011;
  localparam logic [6:0] c_JAL  = 7'b1101111;
  localparam logic [6:0] c_JALR = 7'b1100111;
  localparam logic [6:0] c_BAD  = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       instr_done;
    logic       illegal;
    logic       timeout;
  } obs_t;

  typedef struct packed {
    logic rdy;
    logic hold_op;
    obs_t o;
  } step_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  bit   m_illegal;
  bit   m_timeout;
  step_t plan[$];

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_TIMEOUT(c_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t a;
    a.mem_req    = bus.mem_req;
    a.mem_we     = bus.mem_we;
    a.iord       = bus.iord;
    a.ir_write   = bus.ir_write;
    a.pc_write   = bus.pc_write;
    a.alu_src    = bus.alu_src;
    a.alu_op     = bus.alu_op;
    a.mem_to_reg = bus.mem_to_reg;
    a.reg_write  = bus.reg_write;
    a.branch     = bus.branch;
    a.jump       = bus.jump;
    a.instr_done = bus.instr_done;
    a.illegal    = bus.illegal;
    a.timeout    = bus.timeout;
    return a;
  endfunction

  task automatic check(string tag, obs_t exp);
    obs_t act;
    act = sample();
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  // Reference model: expand one instruction into its expected per-cycle outputs.
  function automatic void push(logic rdy, logic hold, obs_t o);
    step_t s;
    o.illegal = m_illegal;
    o.timeout = m_timeout;
    s.rdy     = rdy;
    s.hold_op = hold;
    s.o       = o;
    plan.push_back(s);
  endfunction

  function automatic void trap_tail();
    for (int i = 0; i < 3; i++) push(1'($urandom), 1'b0, '0);
  endfunction

  // A request phase answered after 'waits' idle cycles, or timing out after c_TO.
  function automatic bit req_phase(int waits, obs_t base, obs_t acc);
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        push(1'b1, 1'b0, acc);
        return 1'b1;
      end
      push(1'b0, 1'b0, base);
      if (i == c_TO - 1) begin
        m_timeout = 1'b1;
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic void plan_instr(logic [6:0] op, int wf, int wm);
    obs_t o;
    obs_t a;
    plan.delete();
    o = '0; o.mem_req = 1'b1;
    a = o;  a.ir_write = 1'b1; a.pc_write = 1'b1;
    if (!req_phase(wf, o, a)) begin trap_tail(); return; end
    push(1'($urandom), 1'b1, '0);
    o = '0;
    case (op)
      c_R, c_I: begin
        o.alu_src = (op == c_I);
        o.alu_op  = 2'b10;
        push(1'($urandom), 1'b0, o);
        o.reg_write = 1'b1; o.instr_done = 1'b1;
        push(1'($urandom), 1'b0, o);
      end
      c_LW: begin
        o.alu_src = 1'b1; o.alu_op = 2'b00;
        push(1'($urandom), 1'b0, o);
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1;
        if (!req_phase(wm, o, o)) begin trap_tail(); return; end
        o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        push(1'($urandom), 1'b0, o);
      end
      c_SW: begin
        o.alu_src = 1'b1; o.alu_op = 2'b00;
        push(1'($urandom), 1'b0, o);
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = 1'b1; o.alu_src = 1'b1;
        a = o;  a.instr_done = 1'b1;
        if (!req_phase(wm, o, a)) begin trap_tail(); return; end
      end
      c_BR: begin
        o.branch = 1'b1; o.alu_op = 2'b01; o.instr_done = 1'b1;
        push(1'($urandom), 1'b0, o);
      end
      c_JAL, c_JALR: begin
        o.jump = 1'b1; o.reg_write = 1'b1; o.alu_op = 2'b11; o.instr_done = 1'b1;
        push(1'($urandom), 1'b0, o);
      end
      default: begin
        m_illegal = 1'b1;
        trap_tail();
      end
    endcase
  endfunction

  // Opcode is only held during DECODE; every other cycle gets noise.
  task automatic run_plan(string tag, logic [6:0] op, int n);
    for (int i = 0; i < n && i < plan.size(); i++) begin
      @(negedge clk);
      bus.mem_ready = plan[i].rdy;
      bus.opcode    = plan[i].hold_op ? op : 7'($urandom);
      #1;
      check($sformatf("%s[%0d]", tag, i), plan[i].o);
    end
  endtask

  task automatic run_instr(string tag, logic [6:0] op, int wf, int wm);
    plan_instr(op, wf, wm);
    run_plan(tag, op, plan.size());
  endtask

  task automatic do_reset(bit wait_edge);
    if (wait_edge) begin
      @(negedge clk);
      #1;
    end
    #1;
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    m_illegal     = 1'b0;
    m_timeout     = 1'b0;
    #1;
    check("reset_async", '0);
    @(negedge clk);
    #1;
    check("reset_held", '0);
    reset = 1'b0;
    #1;
    check("post_reset_idle", '0);
  endtask

  initial begin
    logic [6:0] ops [7];
    obs_t       o;
    ops = '{c_R, c_I, c_LW, c_SW, c_BR, c_JAL, c_JALR};
    n_checks      = 0;
    n_fail        = 0;
    m_illegal     = 1'b0;
    m_timeout     = 1'b0;
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = '0;

    do_reset(1'b1);
    run_instr("r_zero_wait", c_R, 0, 0);
    run_instr("lw_2_2", c_LW, 2, 2);
    run_instr("jalr", c_JALR, 0, 0);
    run_instr("sw", c_SW, 1, 0);
    run_instr("branch", c_BR, 0, 0);
    run_instr("jal", c_JAL, 1, 0);
    run_instr("itype", c_I, 0, 0);
    run_instr("fetch_accept_last", c_R, c_TO - 1, 0);
    run_instr("memrd_accept_last", c_LW, 0, c_TO - 1);
    run_instr("memwr_accept_last", c_SW, 0, c_TO - 1);

    for (int k = 0; k < 30; k++) begin
      run_instr("random", ops[$urandom_range(0, 6)],
                $urandom_range(0, c_TO - 1), $urandom_range(0, c_TO - 1));
    end

    run_instr("illegal", c_BAD, 0, 0);
    do_reset(1'b1);
    run_instr("after_illegal", c_BR, 0, 0);
    run_instr("fetch_timeout", c_R, c_TO, 0);
    do_reset(1'b1);
    run_instr("memrd_timeout", c_LW, 1, c_TO + 2);
    do_reset(1'b1);
    run_instr("memwr_timeout", c_SW, 0, c_TO);
    do_reset(1'b1);

    // Reset while a store is waiting on memory.
    plan_instr(c_SW, 0, 3);
    run_plan("sw_abandon", c_SW, 4);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = 1'b1; o.alu_src = 1'b1;
    check("memwr_before_reset", o);
    do_reset(1'b0);
    run_instr("fetch_after_abandon", c_R, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
